fabric_uart_rx: RTL

Fabric UART receiver that deserialises the 8-bit async serial stream driven onto the system's TX pins by the MSS MMUART or a fabric UART. It presents received bytes through a small show-ahead FIFO with a valid/ready handshake. It sits in the FPGA fabric on the FAB_CCC_GL0 clock domain, in loopback and bridge designs next to the system block.

---
 rtl/fabric_uart_rx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fabric_uart_rx.sv
// fabric_uart_rx
// Receives 8-bit async serial frames (start, 8 data bits LSB first, optional
// parity, one stop bit) sampled at 16x oversampling, and queues each byte with
// its parity-error flag in a small show-ahead FIFO.
//
// Parameters:
//   BAUD_DIV   - clk cycles per 16x oversample tick (2..65535)
//   PARITY     - 0 none, 1 even, 2 odd
//   FIFO_DEPTH - receive FIFO entries, power of two, >= 2
// Ports:
//   clk, reset_n  - fabric clock, asynchronous active-low reset
//   rx            - serial input, idle high, asynchronous to clk
//   rx_data       - head-of-FIFO byte
//   rx_perr       - parity-error flag stored with the head byte
//   rx_valid      - FIFO not empty
//   rx_ready      - consumer accepts the head byte
//   framing_err   - one-cycle pulse, stop bit sampled low
//   overflow      - one-cycle pulse, byte dropped on a full FIFO
//   rx_busy       - receive FSM not idle
//   dbg_state     - current FSM state encoding
//
// Handshake: a byte transfers on every rising clk edge where rx_valid and
// rx_ready are both high; rx_data/rx_perr are stable while rx_valid is high
// and rx_ready is low, and rx_valid never depends on rx_ready.
module fabric_uart_rx #(
    parameter int BAUD_DIV   = 27,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overflow,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic        rx_meta, rx_sync;
    logic [15:0] div_cnt;
    logic        tick;
    logic [3:0]  smp_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        perr;

    logic        smp_clr, shift_en, par_en, push, ferr_set;
    logic        mid_start, bit_done;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok;

    // Two-flop synchroniser; idles at 1 so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running oversample tick.
    assign tick = (div_cnt == 16'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     smp_cnt <= '0;
        else if (smp_clr) smp_cnt <= '0;
        else if (tick)    smp_cnt <= smp_cnt + 4'd1;
    end

    // Start bit is checked on the tick that takes the count to 7 (mid-bit);
    // later bits on the tick where the count wraps 15 -> 0, one full bit on.
    assign mid_start = tick && (smp_cnt == 4'd6);
    assign bit_done  = tick && (smp_cnt == 4'd15);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        smp_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_sync) begin
                    state_nxt = S_START;
                    smp_clr   = 1'b1;
                end
            end
            S_START: begin
                if (mid_start) begin
                    if (!rx_sync) begin
                        state_nxt = S_DATA;
                        smp_clr   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (bit_done) begin
                    par_en    = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (rx_sync) begin
                        push      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath. bit_cnt and perr are cleared while idle so each frame
    // starts fresh; with PARITY = 0 perr is never set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                bit_cnt <= '0;
                perr    <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_en)
                perr <= (^shreg) ^ rx_sync ^ (PARITY == 2);
        end
    end

    // Show-ahead FIFO; the extra pointer MSB separates full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= {perr, shreg};
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            overflow    <= push && full && !pop;
            framing_err <= ferr_set;
        end
    end

    assign rx_data   = mem[rd_ptr[AW-1:0]][7:0];
    assign rx_perr   = mem[rd_ptr[AW-1:0]][8];
    assign rx_valid  = !empty;
    assign rx_busy   = (state != S_IDLE);
    assign dbg_state = state;

endmodule
